// File: rtl/dram_arb_pkg.sv
// dram_arb_pkg: shared state encoding, port indices and counter sizing
// for the Tawas data RAM arbiter.
package dram_arb_pkg;

    typedef enum logic [1:0] {IDLE, LOCK_A, LOCK_B} state_t;

    localparam int PORT_A = 0;
    localparam int PORT_B = 1;

    function automatic int lock_cnt_w(input int max_lock);
        return $clog2(max_lock) + 1;
    endfunction

endpackage

// File: rtl/dram_arb_pick.sv
// dram_arb_pick: combinational two-way pick returning a one-hot grant
// (bit PORT_A = port A, bit PORT_B = port B).
module dram_arb_pick
    import dram_arb_pkg::*;
#(
    parameter int PRIO_MODE = 0
) (
    input  logic [1:0] i_req,
    input  logic       i_last_gnt,
    input  state_t     i_state,
    output logic [1:0] o_gnt
);

    logic w_a_first;

    // On a tie in IDLE, A wins under fixed priority or when B was served last
    assign w_a_first = (PRIO_MODE != 0) || (i_last_gnt == 1'(PORT_B));

    always_comb begin
        o_gnt = 2'b00;
        case (i_state)
            IDLE:    o_gnt = (&i_req) ? (w_a_first ? 2'b01 : 2'b10) : i_req;
            LOCK_A:  o_gnt = {1'b0, i_req[PORT_A]};
            LOCK_B:  o_gnt = {i_req[PORT_B], 1'b0};
            default: o_gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/dram_arb.sv
// dram_arb: two-port arbiter for the single-port Tawas data RAM with
// registered read return and a bounded bus lock for atomic RMW.
module dram_arb
    import dram_arb_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int PRIO_MODE = 0,
    parameter int MAX_LOCK  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_req,
    input  logic              a_wr,
    input  logic              a_lock,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [3:0]        a_mask,
    input  logic [31:0]       a_wdata,
    output logic              a_gnt,
    output logic              a_rvld,
    output logic [31:0]       a_rdata,
    input  logic              b_req,
    input  logic              b_wr,
    input  logic              b_lock,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [3:0]        b_mask,
    input  logic [31:0]       b_wdata,
    output logic              b_gnt,
    output logic              b_rvld,
    output logic [31:0]       b_rdata,
    output logic              ram_cs,
    output logic              ram_wr,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [3:0]        ram_mask,
    output logic [31:0]       ram_din,
    input  logic [31:0]       ram_dout
);

    localparam int CW = lock_cnt_w(MAX_LOCK);

    state_t        r_state, w_state_nx;
    logic          r_last, w_last_nx;
    logic [CW-1:0] r_cnt, w_cnt_nx;
    logic          r_a_rvld, r_b_rvld;
    logic [1:0]    w_pick, w_gnt;
    logic          w_cap;

    dram_arb_pick #(.PRIO_MODE(PRIO_MODE)) u_pick (
        .i_req      ({b_req, a_req}),
        .i_last_gnt (r_last),
        .i_state    (r_state),
        .o_gnt      (w_pick)
    );

    // Grants are held off combinationally while reset is asserted
    assign w_gnt = w_pick & {2{rst_n}};
    assign a_gnt = w_gnt[PORT_A];
    assign b_gnt = w_gnt[PORT_B];

    assign ram_cs   = |w_gnt;
    assign ram_wr   = w_gnt[PORT_B] ? b_wr    : a_wr;
    assign ram_addr = w_gnt[PORT_B] ? b_addr  : a_addr;
    assign ram_mask = w_gnt[PORT_B] ? b_mask  : a_mask;
    assign ram_din  = w_gnt[PORT_B] ? b_wdata : a_wdata;

    assign a_rvld  = r_a_rvld;
    assign b_rvld  = r_b_rvld;
    assign a_rdata = r_a_rvld ? ram_dout : '0;
    assign b_rdata = r_b_rvld ? ram_dout : '0;

    assign w_cap = (r_cnt == CW'(MAX_LOCK - 1));

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt + 1'b1;
        w_last_nx  = w_gnt[PORT_B] ? 1'b1 : (w_gnt[PORT_A] ? 1'b0 : r_last);
        case (r_state)
            IDLE: begin
                w_cnt_nx = '0;
                if (a_gnt && a_lock)
                    w_state_nx = LOCK_A;
                else if (b_gnt && b_lock)
                    w_state_nx = LOCK_B;
            end
            LOCK_A: begin
                if (w_cap) begin
                    w_state_nx = IDLE;
                    w_last_nx  = 1'(PORT_A);
                end else if (a_gnt && !a_lock)
                    w_state_nx = IDLE;
            end
            LOCK_B: begin
                if (w_cap) begin
                    w_state_nx = IDLE;
                    w_last_nx  = 1'(PORT_B);
                end else if (b_gnt && !b_lock)
                    w_state_nx = IDLE;
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_last   <= 1'(PORT_B);
            r_cnt    <= '0;
            r_a_rvld <= 1'b0;
            r_b_rvld <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_last   <= w_last_nx;
            r_cnt    <= w_cnt_nx;
            r_a_rvld <= a_gnt & ~a_wr;
            r_b_rvld <= b_gnt & ~b_wr;
        end
    end

endmodule

// File: tb/tb_dram_arb.sv
// tb_dram_arb: drives a round-robin and a fixed-priority arbiter with the
// same directed stimulus and checks both against a rule-level model.
module tb_dram_arb;

    localparam int ADDR_W   = 32;
    localparam int MAX_LOCK = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        a_req = 0, a_wr = 0, a_lock = 0, b_req = 0, b_wr = 0, b_lock = 0;
    logic [31:0] a_addr = 0, b_addr = 0, a_wdata = 0, b_wdata = 0;
    logic [3:0]  a_mask = 0, b_mask = 0;

    logic [1:0]  a_gnt, b_gnt, a_rvld, b_rvld, ram_cs, ram_wr;
    logic [31:0] a_rdata [2];
    logic [31:0] b_rdata [2];
    logic [31:0] ram_addr [2];
    logic [31:0] ram_din [2];
    logic [31:0] ram_dout [2];
    logic [3:0]  ram_mask [2];

    int n_chk = 0;
    int n_fail = 0;

    // Instance 0 is round-robin, instance 1 is fixed priority
    for (genvar m = 0; m < 2; m++) begin : g_dut
        dram_arb #(.ADDR_W(ADDR_W), .PRIO_MODE(m), .MAX_LOCK(MAX_LOCK)) u_dut (
            .clk(clk), .rst_n(rst_n),
            .a_req(a_req), .a_wr(a_wr), .a_lock(a_lock), .a_addr(a_addr),
            .a_mask(a_mask), .a_wdata(a_wdata), .a_gnt(a_gnt[m]),
            .a_rvld(a_rvld[m]), .a_rdata(a_rdata[m]),
            .b_req(b_req), .b_wr(b_wr), .b_lock(b_lock), .b_addr(b_addr),
            .b_mask(b_mask), .b_wdata(b_wdata), .b_gnt(b_gnt[m]),
            .b_rvld(b_rvld[m]), .b_rdata(b_rdata[m]),
            .ram_cs(ram_cs[m]), .ram_wr(ram_wr[m]), .ram_addr(ram_addr[m]),
            .ram_mask(ram_mask[m]), .ram_din(ram_din[m]), .ram_dout(ram_dout[m])
        );
    end

    function automatic logic [31:0] init_word(input int i);
        logic [13:0] w;
        w = i[13:0];
        return (w == 14'h40) ? 32'hDEADBEEF :
               (w == 14'h10) ? 32'h11223344 : ({18'h0, w} ^ 32'h5A5A0000);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] din,
                                          input logic [3:0] mk);
        merge = old;
        for (int b = 0; b < 4; b++)
            if (mk[b]) merge[8*b +: 8] = din[8*b +: 8];
    endfunction

    function automatic int key(input int m, input logic [31:0] addr);
        return m * 16384 + int'(addr[15:2]);
    endfunction

    // RAM seen by each DUT (registered read, byte-masked write)
    logic [31:0] dmem [int];
    function automatic logic [31:0] dget(input int k);
        return dmem.exists(k) ? dmem[k] : init_word(k);
    endfunction

    always @(posedge clk)
        for (int m = 0; m < 2; m++)
            if (ram_cs[m]) begin
                if (ram_wr[m])
                    dmem[key(m, ram_addr[m])] = merge(dget(key(m, ram_addr[m])), ram_din[m], ram_mask[m]);
                else
                    ram_dout[m] <= dget(key(m, ram_addr[m]));
            end

    // Reference memory owned by the model
    logic [31:0] rmem [int];
    function automatic logic [31:0] rget(input int k);
        return rmem.exists(k) ? rmem[k] : init_word(k);
    endfunction

    task automatic check(input int m, input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (mode %0d): got %h expected %h", nm, m, act, exp);
        end
    endtask

    // Model state: owner of the lock (-1 none), cycles spent locked, last winner
    int          m_own [2];
    int          m_held [2];
    int          m_last [2];
    logic        m_rv [2][2];
    logic [31:0] m_rd [2][2];

    always @(negedge clk) begin
        logic [1:0]  rq, wr, lk;
        logic [31:0] ad [2];
        logic [31:0] wd [2];
        logic [3:0]  mk [2];
        int          g, p, k;
        rq = {b_req, a_req};
        wr = {b_wr, a_wr};
        lk = {b_lock, a_lock};
        ad[0] = a_addr;  ad[1] = b_addr;
        wd[0] = a_wdata; wd[1] = b_wdata;
        mk[0] = a_mask;  mk[1] = b_mask;
        for (int m = 0; m < 2; m++) begin
            if (!rst_n) begin
                check(m, "rst_a_gnt", a_gnt[m], 0);
                check(m, "rst_b_gnt", b_gnt[m], 0);
                check(m, "rst_ram_cs", ram_cs[m], 0);
                check(m, "rst_a_rvld", a_rvld[m], 0);
                check(m, "rst_b_rvld", b_rvld[m], 0);
                m_own[m] = -1;
                m_held[m] = 0;
                m_last[m] = 1;
                m_rv[m][0] = 0;
                m_rv[m][1] = 0;
            end else begin
                if (m_own[m] < 0)
                    g = (rq == 2'b11) ? ((m == 1) ? 0 : 1 - m_last[m]) :
                        rq[0] ? 0 : rq[1] ? 1 : -1;
                else
                    g = rq[m_own[m]] ? m_own[m] : -1;
                p = (g < 0) ? 0 : g;
                check(m, "a_gnt", a_gnt[m], g == 0);
                check(m, "b_gnt", b_gnt[m], g == 1);
                check(m, "ram_cs", ram_cs[m], g >= 0);
                check(m, "ram_wr", ram_wr[m], wr[p]);
                check(m, "ram_addr", ram_addr[m], ad[p]);
                check(m, "ram_mask", ram_mask[m], mk[p]);
                check(m, "ram_din", ram_din[m], wd[p]);
                check(m, "a_rvld", a_rvld[m], m_rv[m][0]);
                check(m, "b_rvld", b_rvld[m], m_rv[m][1]);
                check(m, "a_rdata", a_rdata[m], m_rv[m][0] ? m_rd[m][0] : 32'h0);
                check(m, "b_rdata", b_rdata[m], m_rv[m][1] ? m_rd[m][1] : 32'h0);
                for (int q = 0; q < 2; q++) begin
                    m_rv[m][q] = (g == q) && !wr[q];
                    if (g == q) begin
                        k = key(m, ad[q]);
                        if (wr[q]) rmem[k] = merge(rget(k), wd[q], mk[q]);
                        else m_rd[m][q] = rget(k);
                    end
                end
                if (m_own[m] < 0) begin
                    if (g >= 0 && lk[g]) begin
                        m_own[m] = g;
                        m_held[m] = 0;
                    end
                end else if (m_held[m] == MAX_LOCK - 1) begin
                    m_last[m] = m_own[m];
                    m_own[m] = -1;
                end else if (g == m_own[m] && !lk[g])
                    m_own[m] = -1;
                else
                    m_held[m]++;
                if (g >= 0) m_last[m] = g;
            end
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg;
        @(negedge clk);
        #1;
    endtask

    task automatic quiet;
        a_req = 0; a_wr = 0; a_lock = 0; a_mask = 0;
        b_req = 0; b_wr = 0; b_lock = 0; b_mask = 0;
    endtask

    task automatic do_reset;
        rst_n = 0;
        step;
        step;
        rst_n = 1;
    endtask

    int found [2];

    initial begin
        step;
        at_neg;
        for (int m = 0; m < 2; m++) begin
            check(m, "reset_a_gnt", a_gnt[m], 0);
            check(m, "reset_ram_cs", ram_cs[m], 0);
            check(m, "reset_a_rvld", a_rvld[m], 0);
        end
        step;
        rst_n = 1;

        // Single read from A
        a_req = 1; a_addr = 32'h100;
        at_neg;
        for (int m = 0; m < 2; m++) begin
            check(m, "t1_a_gnt", a_gnt[m], 1);
            check(m, "t1_ram_addr", ram_addr[m], 32'h100);
        end
        step;
        quiet;
        at_neg;
        for (int m = 0; m < 2; m++) begin
            check(m, "t1_a_rvld", a_rvld[m], 1);
            check(m, "t1_a_rdata", a_rdata[m], 32'hDEADBEEF);
            check(m, "t1_b_rvld", b_rvld[m], 0);
        end

        // Both ports read for four cycles, straight out of reset
        step;
        do_reset;
        a_req = 1; a_addr = 32'h200;
        b_req = 1; b_addr = 32'h300;
        for (int c = 0; c < 4; c++) begin
            at_neg;
            check(0, "t2_rr_a_gnt", a_gnt[0], (c % 2) == 0);
            check(0, "t2_rr_b_gnt", b_gnt[0], (c % 2) == 1);
            check(1, "t2_fp_a_gnt", a_gnt[1], 1);
            check(1, "t2_fp_b_gnt", b_gnt[1], 0);
            if (c > 0) check(0, "t2_rr_a_rvld", a_rvld[0], (c % 2) == 1);
            step;
        end
        a_req = 0;
        at_neg;
        check(1, "t2_fp_b_gnt_after", b_gnt[1], 1);
        check(0, "t2_rr_b_rvld_last", b_rvld[0], 1);
        check(0, "t2_rr_b_rdata_last", b_rdata[0], 32'h5A5A00C0);
        check(1, "t2_fp_a_rdata_last", a_rdata[1], 32'h5A5A0080);

        // Locked read-modify-write from A while B keeps requesting
        step;
        quiet;
        do_reset;
        a_req = 1; a_lock = 1; a_addr = 32'h40;
        b_req = 1; b_addr = 32'h80;
        at_neg;
        for (int m = 0; m < 2; m++) begin
            check(m, "t3_rd_a_gnt", a_gnt[m], 1);
            check(m, "t3_rd_b_gnt", b_gnt[m], 0);
        end
        step;
        a_wr = 1; a_lock = 0; a_mask = 4'b0001; a_wdata = 32'h000000AA;
        at_neg;
        for (int m = 0; m < 2; m++) begin
            check(m, "t3_wr_a_gnt", a_gnt[m], 1);
            check(m, "t3_wr_b_gnt", b_gnt[m], 0);
            check(m, "t3_rd_data", a_rdata[m], 32'h11223344);
        end
        step;
        a_req = 0; a_wr = 0; a_mask = 0;
        at_neg;
        for (int m = 0; m < 2; m++) begin
            check(m, "t3_b_gnt_after", b_gnt[m], 1);
            check(m, "t3_ram_word", dget(key(m, 32'h40)), 32'h112233AA);
        end

        // Runaway lock: A locks then idles, B waits for the forced release
        step;
        quiet;
        do_reset;
        a_req = 1; a_lock = 1; a_addr = 32'h500;
        b_req = 1; b_addr = 32'h600;
        at_neg;
        for (int m = 0; m < 2; m++) check(m, "t4_a_gnt", a_gnt[m], 1);
        step;
        a_req = 0; a_lock = 0;
        found[0] = 0;
        found[1] = 0;
        for (int k = 1; k <= 12; k++) begin
            at_neg;
            for (int m = 0; m < 2; m++)
                if (b_gnt[m] && found[m] == 0) found[m] = k;
            step;
        end
        for (int m = 0; m < 2; m++) check(m, "t4_b_wait", found[m], 5);

        // Async reset while B holds the lock with a read return pending
        quiet;
        do_reset;
        b_req = 1; b_lock = 1; b_addr = 32'h700;
        at_neg;
        for (int m = 0; m < 2; m++) check(m, "t5_b_gnt", b_gnt[m], 1);
        step;
        a_req = 1; a_addr = 32'h704;
        #1;
        for (int m = 0; m < 2; m++) begin
            check(m, "t5_b_rvld_pending", b_rvld[m], 1);
            check(m, "t5_b_gnt_locked", b_gnt[m], 1);
        end
        rst_n = 0;
        #1;
        for (int m = 0; m < 2; m++) begin
            check(m, "t5_a_rvld", a_rvld[m], 0);
            check(m, "t5_b_rvld", b_rvld[m], 0);
            check(m, "t5_a_gnt", a_gnt[m], 0);
            check(m, "t5_b_gnt", b_gnt[m], 0);
            check(m, "t5_ram_cs", ram_cs[m], 0);
        end
        step;
        rst_n = 1;
        b_lock = 0;
        at_neg;
        for (int m = 0; m < 2; m++) begin
            check(m, "t5_tie_a_gnt", a_gnt[m], 1);
            check(m, "t5_tie_b_gnt", b_gnt[m], 0);
        end
        step;
        quiet;
        step;
        step;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
